// File: rtl/uart_tx_gy_26.sv
// uart_tx_gy_26: UART frame serialiser (start bit, LSB-first data, optional parity, stop bit).
// Latency: txd falls on the edge that accepts tx_start; a frame lasts (2+DATA_BITS+par)*BPS_DIV clocks.
// Backpressure: none; tx_start is ignored while tx_busy is high and nothing is queued.
module uart_tx_gy_26 #(
  parameter int BPS_DIV   = 5208,  // clocks per bit, 4..8191
  parameter int DATA_BITS = 8,     // data bits per frame, 5..8
  parameter int PARITY    = 0      // 0 = none, 1 = odd, 2 = even, 3 behaves as none
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  // Frame sequencer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Last count of a bit period and index of the final data bit
  localparam logic [12:0] BAUD_LAST = 13'(BPS_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);

  // Only the two defined parity modes insert a parity bit; anything else sends none
  localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = (PARITY == 1);

  // Bits of tx_data that belong to the frame; the rest never reach the line or the parity
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  // Registered state
  logic [2:0]  r_state;
  logic [12:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_txd;
  logic        r_busy;
  logic        r_done;

  // Combinational helpers
  logic [2:0]  w_next_state;
  logic        w_next_txd;
  logic        w_accept;
  logic        w_bit_end;
  logic        w_last_bit;
  logic [7:0]  w_data;
  logic        w_par_bit;

  // A request is only looked at while idle, including the tx_done cycle
  assign w_accept   = (r_state == S_IDLE) && tx_start;

  // Wrap of the bit-period counter marks the edge where the line moves to the next bit
  assign w_bit_end  = (r_state != S_IDLE) && (r_baud_cnt == BAUD_LAST);

  // The shift register's bit 0 is the data bit currently on the line
  assign w_last_bit = (r_bit_cnt == BIT_LAST);

  // Parity is computed on the masked byte at acceptance so later tx_data changes cannot disturb it
  assign w_data     = tx_data & DATA_MASK;
  assign w_par_bit  = PAR_ODD ? ~^w_data : ^w_data;

  // Next-state decode for the frame sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end && w_last_bit) begin
          w_next_state = PAR_EN ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (w_bit_end) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Line value for the next bit period, chosen one clock early so txd can be a flop
  always_comb begin
    w_next_txd = r_txd;
    case (r_state)
      S_IDLE: begin
        w_next_txd = ~tx_start;
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_txd = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (w_last_bit) begin
            w_next_txd = PAR_EN ? r_par : 1'b1;
          end else begin
            w_next_txd = r_shift[1];
          end
        end
      end
      S_PAR: begin
        if (w_bit_end) begin
          w_next_txd = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_next_txd = 1'b1;
        end
      end
      default: begin
        w_next_txd = 1'b1;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bit-period counter: free-runs 0..BPS_DIV-1 while a frame is active, parked at 0 when idle
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) begin
      r_baud_cnt <= 13'd0;
    end else if (w_bit_end) begin
      r_baud_cnt <= 13'd0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 13'd1;
    end
  end

  // Data-bit index, advanced at the end of every data bit and cleared after the last one
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_bit_cnt <= 4'd0;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_bit_cnt <= w_last_bit ? 4'd0 : (r_bit_cnt + 4'd1);
    end
  end

  // Shift register: loads the frame byte at acceptance and moves right after each data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= 8'd0;
    end else if (w_accept) begin
      r_shift <= w_data;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Parity bit captured together with the data byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= w_par_bit;
    end
  end

  // Registered outputs; tx_done marks the first idle cycle after the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_txd  <= w_next_txd;
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (r_state == S_STOP) && w_bit_end;
    end
  end

  assign txd     = r_txd;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_gy_26.sv
// tb_uart_tx_gy_26: directed checks of the UART transmitter with several parameter sets.
// Latency: sampled on falling edges; index n of a capture is the state after the nth edge past acceptance.
// Backpressure: n/a (bench drives tx_start pulses and holds).
module tb_uart_tx_gy_26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: BPS 16 no parity, e: even, o: odd, t: parity code 3, f: default parameters
  logic rst_a, start_a, txd_a, busy_a, done_a; logic [7:0] data_a;
  logic rst_e, start_e, txd_e, busy_e, done_e; logic [7:0] data_e;
  logic rst_o, start_o, txd_o, busy_o, done_o; logic [7:0] data_o;
  logic rst_t, start_t, txd_t, busy_t, done_t; logic [7:0] data_t;
  logic rst_f, start_f, txd_f, busy_f, done_f; logic [7:0] data_f;

  uart_tx_gy_26 #(.BPS_DIV(16), .DATA_BITS(8), .PARITY(0)) u_a (
    .clk(clk), .rst(rst_a), .tx_start(start_a), .tx_data(data_a),
    .txd(txd_a), .tx_busy(busy_a), .tx_done(done_a));
  uart_tx_gy_26 #(.BPS_DIV(16), .DATA_BITS(8), .PARITY(2)) u_e (
    .clk(clk), .rst(rst_e), .tx_start(start_e), .tx_data(data_e),
    .txd(txd_e), .tx_busy(busy_e), .tx_done(done_e));
  uart_tx_gy_26 #(.BPS_DIV(16), .DATA_BITS(8), .PARITY(1)) u_o (
    .clk(clk), .rst(rst_o), .tx_start(start_o), .tx_data(data_o),
    .txd(txd_o), .tx_busy(busy_o), .tx_done(done_o));
  uart_tx_gy_26 #(.BPS_DIV(16), .DATA_BITS(8), .PARITY(3)) u_t (
    .clk(clk), .rst(rst_t), .tx_start(start_t), .tx_data(data_t),
    .txd(txd_t), .tx_busy(busy_t), .tx_done(done_t));
  uart_tx_gy_26 u_f (
    .clk(clk), .rst(rst_f), .tx_start(start_f), .tx_data(data_f),
    .txd(txd_f), .tx_busy(busy_f), .tx_done(done_f));

  int checks = 0;
  int failures = 0;

  logic cap_txd  [52200];
  logic cap_busy [52200];
  logic cap_done [52200];

  // Record n falling-edge samples of one instance's outputs
  task automatic capture(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      case (which)
        0: begin cap_txd[k] = txd_a; cap_busy[k] = busy_a; cap_done[k] = done_a; end
        1: begin cap_txd[k] = txd_e; cap_busy[k] = busy_e; cap_done[k] = done_e; end
        2: begin cap_txd[k] = txd_o; cap_busy[k] = busy_o; cap_done[k] = done_o; end
        3: begin cap_txd[k] = txd_t; cap_busy[k] = busy_t; cap_done[k] = done_t; end
        default: begin cap_txd[k] = txd_f; cap_busy[k] = busy_f; cap_done[k] = done_f; end
      endcase
      @(negedge clk);
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [7:0] d);
    case (which)
      0: begin start_a = s; data_a = d; end
      1: begin start_e = s; data_e = d; end
      2: begin start_o = s; data_o = d; end
      3: begin start_t = s; data_t = d; end
      default: begin start_f = s; data_f = d; end
    endcase
  endtask

  // One-cycle tx_start pulse; returns at the falling edge after the accepting edge (n = 0)
  task automatic start_frame(input int which, input logic [7:0] d);
    @(negedge clk);
    drive(which, 1'b1, d);
    @(negedge clk);
    drive(which, 1'b0, d);
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_e = 1'b1; rst_o = 1'b1; rst_t = 1'b1; rst_f = 1'b1;
    for (int w = 0; w < 5; w++) drive(w, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 5; w++) begin
      capture(w, 1);
      checks++;
      if ({cap_txd[0], cap_busy[0], cap_done[0]} !== 3'b100) begin
        failures++;
        $display("FAIL reset_state dut%0d: txd/busy/done=%b%b%b expected 100",
                 w, cap_txd[0], cap_busy[0], cap_done[0]);
      end
    end
    rst_a = 1'b0; rst_e = 1'b0; rst_o = 1'b0; rst_t = 1'b0; rst_f = 1'b0;
    capture(0, 4);
    checks++;
    if ({cap_txd[3], cap_busy[3], cap_done[3]} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset: txd/busy/done=%b%b%b expected 100",
               cap_txd[3], cap_busy[3], cap_done[3]);
    end
  endtask

  task automatic test_basic;
    logic [9:0] fr;
    int errs, first, nbusy, ndone, nlow;
    fr = 10'b1_01010101_0;  // 0x55: start, 1,0,1,0,1,0,1,0, stop
    start_frame(0, 8'h55);
    capture(0, 180);
    errs = 0; first = -1;
    for (int k = 0; k < 160; k++) begin
      if (cap_txd[k] !== fr[k/16]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL basic_wave: %0d cycles wrong, first at %0d got %b expected %b",
               errs, first, cap_txd[first], fr[first/16]);
    end
    nbusy = 0; ndone = 0; nlow = 0;
    for (int k = 0; k < 180; k++) begin
      if (cap_busy[k] === 1'b1) nbusy++;
      if (cap_done[k] === 1'b1) ndone++;
      if (k >= 160 && cap_txd[k] !== 1'b1) nlow++;
    end
    checks++;
    if (nbusy != 160) begin
      failures++;
      $display("FAIL basic_busy_len: got %0d expected 160", nbusy);
    end
    checks++;
    if ({cap_busy[159], cap_busy[160], cap_done[160]} !== 3'b101 || ndone != 1) begin
      failures++;
      $display("FAIL basic_done: busy159/busy160/done160=%b%b%b pulses=%0d expected 101 pulses=1",
               cap_busy[159], cap_busy[160], cap_done[160], ndone);
    end
    checks++;
    if (nlow != 0) begin
      failures++;
      $display("FAIL basic_idle_high: %0d non-high cycles after frame expected 0", nlow);
    end
  endtask

  task automatic test_parity;
    for (int m = 0; m < 3; m++) begin
      int w, len, errs, first, ndone;
      logic [10:0] fr;
      case (m)
        0: begin w = 1; len = 176; fr = 11'b11_00000111_0; end  // even: parity 1
        1: begin w = 2; len = 176; fr = 11'b10_00000111_0; end  // odd: parity 0
        default: begin w = 3; len = 160; fr = 11'b01_00000111_0; end  // code 3: no parity
      endcase
      start_frame(w, 8'h07);
      capture(w, len + 16);
      errs = 0; first = -1;
      for (int k = 0; k < len; k++) begin
        if (cap_txd[k] !== fr[k/16]) begin
          if (errs == 0) first = k;
          errs++;
        end
      end
      checks++;
      if (errs != 0) begin
        failures++;
        $display("FAIL parity_wave mode%0d: %0d cycles wrong, first at %0d got %b expected %b",
                 m, errs, first, cap_txd[first], fr[first/16]);
      end
      ndone = 0;
      for (int k = 0; k < len + 16; k++) if (cap_done[k] === 1'b1) ndone++;
      checks++;
      if ({cap_busy[len-1], cap_busy[len], cap_done[len], cap_txd[len]} !== 4'b1011 || ndone != 1) begin
        failures++;
        $display("FAIL parity_len mode%0d: busy/busy/done/txd at end=%b%b%b%b pulses=%0d expected 1011 pulses=1",
                 m, cap_busy[len-1], cap_busy[len], cap_done[len], cap_txd[len], ndone);
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [9:0] fr;
    int errs, first, ndone;
    fr = 10'b1_10100011_0;  // 0xA3: 1,1,0,0,0,1,0,1
    start_frame(0, 8'hA3);
    fork
      capture(0, 200);
      begin
        repeat (40) @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF);
        repeat (30) @(negedge clk);
        drive(0, 1'b0, 8'h5A);
      end
    join
    errs = 0; first = -1;
    for (int k = 0; k < 200; k++) begin
      if (cap_txd[k] !== ((k < 160) ? fr[k/16] : 1'b1)) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL busy_ignore_wave: %0d cycles wrong, first at %0d got %b",
               errs, first, cap_txd[first]);
    end
    ndone = 0;
    for (int k = 0; k < 200; k++) if (cap_done[k] === 1'b1) ndone++;
    checks++;
    if (ndone != 1 || cap_done[160] !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore_done: pulses=%0d done160=%b expected pulses=1 done160=1",
               ndone, cap_done[160]);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] fr1, fr2;
    int errs, first, nstop, ndone;
    fr1 = 10'b1_00000000_0;
    fr2 = 10'b1_11111111_0;
    @(negedge clk);
    drive(0, 1'b1, 8'h00);
    @(negedge clk);
    fork
      capture(0, 330);
      begin
        repeat (80) @(negedge clk);
        drive(0, 1'b1, 8'hFF);
      end
    join
    drive(0, 1'b0, 8'hFF);
    errs = 0; first = -1;
    for (int k = 0; k < 160; k++) begin
      if (cap_txd[k] !== fr1[k/16]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL b2b_frame1: %0d cycles wrong, first at %0d", errs, first);
    end
    nstop = 0;
    for (int k = 0; k <= 160; k++) if (cap_txd[k] === 1'b1 && cap_busy[k] === 1'b1) nstop++;
    checks++;
    if (nstop != 16) begin
      failures++;
      $display("FAIL b2b_stop_len: got %0d expected 16", nstop);
    end
    checks++;
    if ({cap_done[160], cap_txd[161], cap_busy[161]} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_restart: done160/txd161/busy161=%b%b%b expected 101",
               cap_done[160], cap_txd[161], cap_busy[161]);
    end
    errs = 0; first = -1;
    for (int k = 161; k < 321; k++) begin
      if (cap_txd[k] !== fr2[(k-161)/16]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL b2b_frame2: %0d cycles wrong, first at %0d", errs, first);
    end
    ndone = 0;
    for (int k = 0; k < 330; k++) if (cap_done[k] === 1'b1) ndone++;
    checks++;
    if (ndone != 2 || cap_done[321] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done: pulses=%0d done321=%b expected pulses=2 done321=1", ndone, cap_done[321]);
    end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [9:0] fr;
    int errs, first, ndone;
    fr = 10'b1_00111100_0;  // 0x3C
    start_frame(0, 8'h3C);
    capture(0, 69);
    errs = 0; first = -1;
    for (int k = 0; k < 69; k++) begin
      if (cap_txd[k] !== fr[k/16]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL reset_mid_prefix: %0d cycles wrong, first at %0d", errs, first);
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({txd_a, busy_a, done_a} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_abort: txd/busy/done=%b%b%b expected 100", txd_a, busy_a, done_a);
    end
    rst_a = 1'b0;
    capture(0, 20);
    ndone = 0;
    for (int k = 0; k < 20; k++) if (cap_done[k] !== 1'b0 || cap_busy[k] !== 1'b0) ndone++;
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d cycles with busy/done active expected 0", ndone);
    end
    start_frame(0, 8'h3C);
    capture(0, 170);
    errs = 0; first = -1;
    for (int k = 0; k < 160; k++) begin
      if (cap_txd[k] !== fr[k/16]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0 || cap_done[160] !== 1'b1 || cap_busy[159] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_refr: %0d cycles wrong, done160=%b busy159=%b expected 0 wrong, 1, 1",
               errs, cap_done[160], cap_busy[159]);
    end
  endtask

  task automatic test_default;
    logic [9:0] fr;
    logic [7:0] rx;
    int errs, first, nbusy, ndone;
    fr = 10'b1_01000001_0;  // 0x41
    start_frame(4, 8'h41);
    capture(4, 52100);
    errs = 0; first = -1;
    for (int k = 0; k < 52080; k++) begin
      if (cap_txd[k] !== fr[k/5208]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL default_wave: %0d cycles wrong, first at %0d got %b", errs, first, cap_txd[first]);
    end
    nbusy = 0; ndone = 0;
    for (int k = 0; k < 52100; k++) begin
      if (cap_busy[k] === 1'b1) nbusy++;
      if (cap_done[k] === 1'b1) ndone++;
    end
    checks++;
    if (nbusy != 52080 || ndone != 1 || cap_done[52080] !== 1'b1) begin
      failures++;
      $display("FAIL default_len: busy=%0d pulses=%0d done52080=%b expected 52080 1 1",
               nbusy, ndone, cap_done[52080]);
    end
    for (int i = 1; i <= 8; i++) rx[i-1] = cap_txd[i*5208 + 2604];
    checks++;
    if (rx !== 8'h41 || cap_txd[2604] !== 1'b0 || cap_txd[9*5208 + 2604] !== 1'b1) begin
      failures++;
      $display("FAIL default_rx: byte=%h start=%b stop=%b expected 41 0 1",
               rx, cap_txd[2604], cap_txd[9*5208 + 2604]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_default;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
